sysid_checker: RTL

Avalon-MM read master that queries the system ID peripheral: word 0 (ID) and word 1 (build timestamp). It compares both words against expected values fixed at build time and reports match flags, so firmware or a bring-up LED can confirm that the loaded image matches the expected Qsys system. It sits beside the NIOS data master on the system interconnect, as a second master on the sysid control slave.

---
 rtl/sysid_pkg.sv | 20 ++
 rtl/sysid_checker.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sysid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysid_pkg : shared types and constants for the system ID checker     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sysid_pkg;

  localparam int   SYSID_DATA_W  = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_state_t;

endpackage
`default_nettype wire

// File: rtl/sysid_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysid_checker : Avalon-MM master reading sysid words 0/1 and         |
// | comparing them against build-time expected values. Rev 1.0           |
// +----------------------------------------------------------------------+
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'd1429586131,
  parameter int unsigned             TIMEOUT_CYCLES = 255,
  parameter bit                      AUTO_START     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    id_match,
  output logic                    ts_match,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  localparam bit              TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int              CNT_W     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  sysid_state_t              r_state;
  sysid_state_t              w_next;
  logic                      w_launch;
  logic                      w_abort;
  logic                      w_stall;
  logic                      w_limit;
  logic [CNT_W-1:0]          r_wait_cnt;
  logic                      r_auto;
  logic                      r_read;
  logic                      r_addr;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_id_match;
  logic                      r_ts_match;
  logic                      r_timeout;
  logic [SYSID_DATA_W-1:0]   r_id_value;
  logic [SYSID_DATA_W-1:0]   r_ts_value;

  // r_wait_cnt holds the stalls already seen, so the limit is hit on stall N
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_abort  = 1'b0;
    w_stall  = ((r_state == RD_ID) || (r_state == RD_TS)) && avm_waitrequest;
    w_limit  = TO_EN && (r_wait_cnt == CNT_LIMIT);
    case (r_state)
      IDLE: begin
        if (start || r_auto) begin
          w_next   = RD_ID;
          w_launch = 1'b1;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          w_next = RD_TS;
        end else if (w_limit) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          w_next = DONE;
        end else if (w_limit) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_auto     <= AUTO_START;
      r_read     <= 1'b0;
      r_addr     <= SYSID_ADDR_ID;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_state <= w_next;
      r_read  <= (w_next == RD_ID) || (w_next == RD_TS);
      r_busy  <= (w_next == RD_ID) || (w_next == RD_TS);
      r_addr  <= (w_next == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      r_done  <= (w_next == DONE);

      if (w_launch) begin
        r_auto     <= 1'b0;
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
        r_timeout  <= 1'b0;
        r_wait_cnt <= '0;
      end else if (w_stall) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if ((r_state == RD_ID) && !avm_waitrequest) begin
        r_id_value <= avm_readdata;
      end

      // Both flags settle on the DONE entry edge; the ID word is already held
      if ((r_state == RD_TS) && !avm_waitrequest) begin
        r_ts_value <= avm_readdata;
        r_id_match <= (r_id_value == EXPECTED_ID);
        r_ts_match <= (avm_readdata == EXPECTED_TS);
      end

      if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign avm_read    = r_read;
  assign avm_address = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule
`default_nettype wire
